// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter with hold limit, plus ROM/RAM window decode
// and error flagging for the shared instruction ROM and data RAM ports.
//   state | meaning
//   IDLE  | no master owns the bus
//   OWN0  | master 0 (core data bus) granted
//   OWN1  | master 1 (loader/debug) granted
module bus_arbiter #(
    parameter logic [31:0] ROM_BASE  = 32'h0400_0000,
    parameter int          ROM_WORDS = 64,
    parameter logic [31:0] RAM_BASE  = 32'h1001_0000,
    parameter int          RAM_WORDS = 32,
    parameter int          MAX_HOLD  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic        m0_wren,
    input  logic        m1_wren,
    input  logic [31:0] m0_wrdata,
    input  logic [31:0] m1_wrdata,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic [31:0] m0_rddata,
    output logic [31:0] m1_rddata,
    output logic        m0_err,
    output logic        m1_err,
    output logic [31:0] s_rom_addr,
    input  logic [31:0] s_rom_rddata,
    output logic        s_ram_wren,
    output logic [31:0] s_ram_addr,
    output logic [31:0] s_ram_wrdata,
    input  logic [31:0] s_ram_rddata
);

    localparam int          HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [31:0] ROM_BYTES = 32'(4 * ROM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t          r_state, w_state_next;
    logic            r_rr, w_rr_next;
    logic [HW-1:0]   r_hold, w_hold_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_rr    <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_next;
            r_rr    <= w_rr_next;
            r_hold  <= w_hold_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rr_next    = r_rr;
        w_hold_next  = r_hold;
        case (r_state)
            IDLE: begin
                if (m0_req && (!m1_req || !r_rr)) w_state_next = OWN0;
                else if (m1_req)                  w_state_next = OWN1;
            end
            OWN0: begin
                if (!m0_req)                            w_state_next = m1_req ? OWN1 : IDLE;
                else if (m1_req && r_hold == HOLD_LAST) w_state_next = OWN1;
            end
            OWN1: begin
                if (!m1_req)                            w_state_next = m0_req ? OWN0 : IDLE;
                else if (m0_req && r_hold == HOLD_LAST) w_state_next = OWN0;
            end
            default: w_state_next = IDLE;
        endcase

        // Entering an ownership state hands priority to the other master.
        if (w_state_next != r_state && w_state_next == OWN0) begin
            w_rr_next   = 1'b1;
            w_hold_next = '0;
        end else if (w_state_next != r_state && w_state_next == OWN1) begin
            w_rr_next   = 1'b0;
            w_hold_next = '0;
        end else if (w_state_next == r_state && r_state != IDLE && r_hold != HOLD_LAST) begin
            w_hold_next = r_hold + 1'b1;
        end
    end

    logic        w_own1;
    logic        w_xfer;
    logic [31:0] w_addr;
    logic        w_wren;
    logic [31:0] w_wrdata;
    logic [31:0] w_rom_off;
    logic [31:0] w_ram_off;
    logic [31:0] w_rom_idx;
    logic [31:0] w_ram_idx;
    logic        w_rom_hit;
    logic        w_ram_hit;
    logic        w_err;
    logic [31:0] w_rddata;

    assign w_own1   = (r_state == OWN1);
    assign w_xfer   = ((r_state == OWN0) && m0_req) || ((r_state == OWN1) && m1_req);
    assign w_addr   = w_own1 ? m1_addr   : m0_addr;
    assign w_wren   = w_own1 ? m1_wren   : m0_wren;
    assign w_wrdata = w_own1 ? m1_wrdata : m0_wrdata;

    // Offsets wrap to large values below the base, so one compare covers both bounds.
    assign w_rom_off = w_addr - ROM_BASE;
    assign w_ram_off = w_addr - RAM_BASE;
    assign w_rom_idx = w_rom_off >> 2;
    assign w_ram_idx = w_ram_off >> 2;
    assign w_rom_hit = (w_rom_off < ROM_BYTES);
    assign w_ram_hit = (w_ram_off < RAM_BYTES);

    assign w_err = w_xfer && ((w_addr[1:0] != 2'b00) || !(w_rom_hit || w_ram_hit)
                              || (w_wren && w_rom_hit));

    always_comb begin
        w_rddata = '0;
        if (w_xfer && !w_err) begin
            if (w_rom_hit)      w_rddata = s_rom_rddata;
            else if (w_ram_hit) w_rddata = s_ram_rddata;
        end
    end

    assign m0_gnt    = (r_state == OWN0);
    assign m1_gnt    = (r_state == OWN1);
    assign m0_rddata = w_own1 ? '0 : w_rddata;
    assign m1_rddata = w_own1 ? w_rddata : '0;
    assign m0_err    = !w_own1 && w_err;
    assign m1_err    = w_own1 && w_err;

    assign s_rom_addr   = (w_xfer && w_rom_hit) ? w_rom_idx : '0;
    assign s_ram_addr   = (w_xfer && w_ram_hit) ? w_ram_idx : '0;
    assign s_ram_wrdata = (w_xfer && w_ram_hit) ? w_wrdata  : '0;
    assign s_ram_wren   = w_xfer && w_ram_hit && w_wren && !w_err;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed steps followed by constrained-random
// traffic, checked against a transaction-level model of grants and decode.
module tb_bus_arbiter;

    localparam logic [31:0] ROM_BASE  = 32'h0400_0000;
    localparam int          ROM_WORDS = 64;
    localparam logic [31:0] RAM_BASE  = 32'h1001_0000;
    localparam int          RAM_WORDS = 32;
    localparam int          MAX_HOLD  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req[2];
    logic        wren[2];
    logic [31:0] addr[2];
    logic [31:0] wdat[2];

    logic        m0_gnt, m1_gnt, m0_err, m1_err, s_ram_wren;
    logic [31:0] m0_rddata, m1_rddata, s_rom_addr, s_rom_rddata;
    logic [31:0] s_ram_addr, s_ram_wrdata, s_ram_rddata;

    logic [31:0] rom_img[ROM_WORDS];
    logic [31:0] ram_slv[RAM_WORDS];
    logic [31:0] mem_ref[RAM_WORDS];

    bus_arbiter #(
        .ROM_BASE(ROM_BASE), .ROM_WORDS(ROM_WORDS), .RAM_BASE(RAM_BASE),
        .RAM_WORDS(RAM_WORDS), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(req[0]), .m1_req(req[1]),
        .m0_addr(addr[0]), .m1_addr(addr[1]),
        .m0_wren(wren[0]), .m1_wren(wren[1]),
        .m0_wrdata(wdat[0]), .m1_wrdata(wdat[1]),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rddata(m0_rddata), .m1_rddata(m1_rddata),
        .m0_err(m0_err), .m1_err(m1_err),
        .s_rom_addr(s_rom_addr), .s_rom_rddata(s_rom_rddata),
        .s_ram_wren(s_ram_wren), .s_ram_addr(s_ram_addr),
        .s_ram_wrdata(s_ram_wrdata), .s_ram_rddata(s_ram_rddata)
    );

    // Slave emulation: combinational ROM/RAM read, RAM write on the clock edge.
    assign s_rom_rddata = (s_rom_addr < ROM_WORDS) ? rom_img[s_rom_addr[5:0]] : 32'hBADB_AD00;
    assign s_ram_rddata = (s_ram_addr < RAM_WORDS) ? ram_slv[s_ram_addr[4:0]] : 32'hBADB_AD11;
    always @(posedge clk)
        if (s_ram_wren === 1'b1 && s_ram_addr < RAM_WORDS)
            ram_slv[s_ram_addr[4:0]] <= s_ram_wrdata;

    int checks = 0;
    int failures = 0;

    // Reference model: owner -1 = nobody, otherwise master number.
    int m_owner, m_rr, m_hold;
    bit          exp_wr;
    int          exp_ai;
    logic [31:0] exp_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_rr    = 0;
        m_hold  = 0;
        exp_wr  = 1'b0;
    endtask

    task automatic check_outputs();
        bit          xfer, rom, ram, err;
        longint      a;
        int          o, ri, ai;
        logic [31:0] rd, wd;
        o = m_owner; xfer = 0; rom = 0; ram = 0; err = 0;
        ri = 0; ai = 0; rd = 0; wd = 0; exp_wr = 0;
        if (o >= 0) xfer = (req[o] === 1'b1);
        if (xfer) begin
            a   = longint'(addr[o]);
            rom = (a >= longint'(ROM_BASE)) && (a < longint'(ROM_BASE) + 4 * ROM_WORDS);
            ram = (a >= longint'(RAM_BASE)) && (a < longint'(RAM_BASE) + 4 * RAM_WORDS);
            err = (a % 4 != 0) || !(rom || ram) || (wren[o] && rom);
            if (rom) ri = int'((a - longint'(ROM_BASE)) / 4);
            if (ram) ai = int'((a - longint'(RAM_BASE)) / 4);
            if (!err) rd = rom ? rom_img[ri] : mem_ref[ai];
            if (ram) wd = wdat[o];
            exp_wr = ram && wren[o] && !err;
        end
        exp_ai = ai;
        exp_wd = wd;
        chk("m0_gnt", m0_gnt, (o == 0));
        chk("m1_gnt", m1_gnt, (o == 1));
        chk("m0_rddata", m0_rddata, (o == 0) ? rd : 32'h0);
        chk("m1_rddata", m1_rddata, (o == 1) ? rd : 32'h0);
        chk("m0_err", m0_err, (o == 0) && err);
        chk("m1_err", m1_err, (o == 1) && err);
        chk("s_rom_addr", s_rom_addr, rom ? ri : 0);
        chk("s_ram_addr", s_ram_addr, ram ? ai : 0);
        chk("s_ram_wrdata", s_ram_wrdata, wd);
        chk("s_ram_wren", s_ram_wren, exp_wr);
    endtask

    task automatic advance();
        int w, o, y;
        o = m_owner;
        if (o < 0) begin
            if (req[0] && req[1]) w = m_rr;
            else if (req[0])      w = 0;
            else if (req[1])      w = 1;
            else                  w = -1;
        end else begin
            y = 1 - o;
            if (!req[o])                               w = req[y] ? y : -1;
            else if (req[y] && m_hold == MAX_HOLD - 1) w = y;
            else                                       w = o;
        end
        if (w >= 0 && w != o) begin
            m_rr   = 1 - w;
            m_hold = 0;
        end else if (w >= 0) begin
            m_hold = (m_hold + 1 > MAX_HOLD - 1) ? MAX_HOLD - 1 : m_hold + 1;
        end
        m_owner = w;
    endtask

    // One bus cycle: check outputs mid-cycle, then clock and step the model.
    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        if (!rst) model_reset();
        else begin
            if (exp_wr) mem_ref[exp_ai] = exp_wd;
            advance();
        end
        #1;
    endtask

    // Single access from IDLE with the other master quiet; captures granted-cycle outputs.
    task automatic access(input int m, input logic [31:0] a, input logic w, input logic [31:0] d,
                          output logic g_o, output logic [31:0] rd_o, output logic err_o,
                          output logic wr_o, output logic [31:0] ra_o);
        req[m] = 1'b1; addr[m] = a; wren[m] = w; wdat[m] = d;
        tick();
        #1;
        g_o   = m ? m1_gnt : m0_gnt;
        rd_o  = m ? m1_rddata : m0_rddata;
        err_o = m ? m1_err : m0_err;
        wr_o  = s_ram_wren;
        ra_o  = (a >= RAM_BASE) ? s_ram_addr : s_rom_addr;
        tick();
        req[m] = 1'b0; wren[m] = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0, 1:    return ROM_BASE + 32'(4 * $urandom_range(0, ROM_WORDS - 1));
            2, 3:    return RAM_BASE + 32'(4 * $urandom_range(0, RAM_WORDS - 1));
            4:       return RAM_BASE + 32'(4 * $urandom_range(0, RAM_WORDS - 1)) + 32'($urandom_range(1, 3));
            5:       return ($urandom_range(0, 1) != 0) ? ROM_BASE + 32'(4 * ROM_WORDS) : RAM_BASE - 32'd4;
            6:       return ($urandom_range(0, 1) != 0) ? RAM_BASE + 32'(4 * RAM_WORDS - 4) : ROM_BASE - 32'd4;
            default: return $urandom;
        endcase
    endfunction

    logic        g, e, wr;
    logic [31:0] rd, ra;
    logic [31:0] keep3;

    initial begin
        for (int i = 0; i < ROM_WORDS; i++) rom_img[i] = {16'hC0DE, 16'(i * 37 + 5)};
        for (int i = 0; i < RAM_WORDS; i++) begin
            mem_ref[i] = $urandom;
            ram_slv[i] = mem_ref[i];
        end
        rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            req[m] = 1'b0; wren[m] = 1'b0; addr[m] = '0; wdat[m] = '0;
        end
        model_reset();

        // Reset state, including a request held during reset.
        tick();
        req[0] = 1'b1; addr[0] = RAM_BASE;
        tick();
        chk("reset_m0_gnt", m0_gnt, 1'b0);
        req[0] = 1'b0;
        rst = 1'b1;
        tick();

        // m0 ROM read of word 2.
        access(0, 32'h0400_0008, 1'b0, 32'h0, g, rd, e, wr, ra);
        chk("tp1_gnt", g, 1'b1);
        chk("tp1_rom_addr", ra, 32'd2);
        chk("tp1_rddata", rd, rom_img[2]);
        chk("tp1_err", e, 1'b0);

        // m1 RAM write then m0 read-back.
        access(1, 32'h1001_0004, 1'b1, 32'hDEAD_BEEF, g, rd, e, wr, ra);
        chk("tp2_wren", wr, 1'b1);
        chk("tp2_wr_index", ra, 32'd1);
        chk("tp2_ram_content", ram_slv[1], 32'hDEAD_BEEF);
        access(0, 32'h1001_0004, 1'b0, 32'h0, g, rd, e, wr, ra);
        chk("tp2_rddata", rd, 32'hDEAD_BEEF);
        chk("tp2_read_wren", wr, 1'b0);

        // Error cases: ROM write, unmapped read, misaligned read.
        access(0, 32'h0400_0000, 1'b1, 32'h1234_5678, g, rd, e, wr, ra);
        chk("err_romwr_err", e, 1'b1);
        chk("err_romwr_rd", rd, 32'h0);
        chk("err_romwr_wren", wr, 1'b0);
        access(1, 32'h2000_0000, 1'b0, 32'h0, g, rd, e, wr, ra);
        chk("err_unmapped_err", e, 1'b1);
        chk("err_unmapped_rd", rd, 32'h0);
        access(0, 32'h1001_0002, 1'b0, 32'h0, g, rd, e, wr, ra);
        chk("err_misaligned_err", e, 1'b1);
        chk("err_misaligned_rd", rd, 32'h0);
        access(0, RAM_BASE + 32'(4 * RAM_WORDS), 1'b1, 32'h5555_AAAA, g, rd, e, wr, ra);
        chk("err_ram_end_err", e, 1'b1);
        chk("err_ram_end_wren", wr, 1'b0);

        // Continuous contention from reset: 8-cycle alternating ownership.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req[0] = 1'b1; addr[0] = ROM_BASE + 32'd12;
        req[1] = 1'b1; addr[1] = RAM_BASE + 32'd8;
        tick();
        for (int k = 0; k < 4 * MAX_HOLD; k++) begin
            chk("hold_pattern_m0", m0_gnt, ((k / MAX_HOLD) % 2) == 0);
            chk("hold_pattern_m1", m1_gnt, ((k / MAX_HOLD) % 2) == 1);
            tick();
        end
        req[0] = 1'b0; req[1] = 1'b0;
        tick();
        tick();

        // Reset asserted in the middle of an m1 RAM write.
        keep3 = mem_ref[3];
        req[1] = 1'b1; addr[1] = RAM_BASE + 32'd12; wren[1] = 1'b1; wdat[1] = 32'hFEED_F00D;
        tick();
        #1;
        check_outputs();
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_m1_gnt", m1_gnt, 1'b0);
        chk("midrst_wren", s_ram_wren, 1'b0);
        model_reset();
        req[1] = 1'b0; wren[1] = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_ram_kept", ram_slv[3], keep3);
        rst = 1'b1;
        tick();

        // After reset rr=0 so m0 wins a tie; m0 is then last owner so m1 wins the next tie.
        req[0] = 1'b1; req[1] = 1'b1;
        addr[0] = ROM_BASE; addr[1] = ROM_BASE + 32'd4;
        tick();
        chk("rr_reset_m0_first", m0_gnt, 1'b1);
        req[0] = 1'b0; req[1] = 1'b0;
        tick();
        tick();
        req[0] = 1'b1; req[1] = 1'b1;
        tick();
        chk("rr_m1_after_m0", m1_gnt, 1'b1);
        req[0] = 1'b0; req[1] = 1'b0;
        tick();
        tick();

        // Random traffic; a waiting master keeps its request stable until granted.
        for (int n = 0; n < 800; n++) begin
            for (int m = 0; m < 2; m++) begin
                if (!(req[m] && m_owner != m)) begin
                    req[m]  = ($urandom_range(0, 3) != 0);
                    addr[m] = rand_addr();
                    wren[m] = ($urandom_range(0, 2) == 0);
                    wdat[m] = $urandom;
                end
            end
            tick();
        end
        req[0] = 1'b0; req[1] = 1'b0;
        tick();
        for (int i = 0; i < RAM_WORDS; i++) chk("final_ram", ram_slv[i], mem_ref[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
